// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants and the queue entry layout used by the
// instruction fetch queue.
package fetch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned FETCH_WIDTH  = 5;
    localparam int unsigned DECODE_WIDTH = 3;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue: accepts up to 5 fetched instructions per cycle
// and presents the oldest 3 to decode; flushes on misprediction.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_valid,
    input  logic [2:0]              fetch_count,
    input  logic [DATA_WIDTH-1:0]   inst_0,
    input  logic [DATA_WIDTH-1:0]   inst_1,
    input  logic [DATA_WIDTH-1:0]   inst_2,
    input  logic [DATA_WIDTH-1:0]   inst_3,
    input  logic [DATA_WIDTH-1:0]   inst_4,
    input  logic [DATA_WIDTH-1:0]   pc_0,
    input  logic [DATA_WIDTH-1:0]   pc_1,
    input  logic [DATA_WIDTH-1:0]   pc_2,
    input  logic [DATA_WIDTH-1:0]   pc_3,
    input  logic [DATA_WIDTH-1:0]   pc_4,
    input  logic                    pred_taken_0,
    input  logic                    pred_taken_1,
    input  logic                    pred_taken_2,
    input  logic                    pred_taken_3,
    input  logic                    pred_taken_4,
    input  logic                    flush,
    input  logic [1:0]              dec_accept,
    output logic                    dec_valid_0,
    output logic                    dec_valid_1,
    output logic                    dec_valid_2,
    output logic [DATA_WIDTH-1:0]   dec_inst_0,
    output logic [DATA_WIDTH-1:0]   dec_inst_1,
    output logic [DATA_WIDTH-1:0]   dec_inst_2,
    output logic [DATA_WIDTH-1:0]   dec_pc_0,
    output logic [DATA_WIDTH-1:0]   dec_pc_1,
    output logic [DATA_WIDTH-1:0]   dec_pc_2,
    output logic                    dec_pred_taken_0,
    output logic                    dec_pred_taken_1,
    output logic                    dec_pred_taken_2,
    output logic                    buble,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   room_t;

    localparam room_t ROOM_MAX  = room_t'(DEPTH);
    localparam cnt_t  BUBLE_TH  = cnt_t'(DEPTH - FETCH_WIDTH);

    ptr_t         head_q, head_d;
    ptr_t         tail_q, tail_d;
    cnt_t         count_q, count_d;
    logic         ovf_q, ovf_d;
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];

    fetch_entry_t slot_ent [FETCH_WIDTH];
    fetch_entry_t dec_ent  [DECODE_WIDTH];
    logic         dec_vld  [DECODE_WIDTH];

    cnt_t  rd;
    room_t room;
    logic  wr_req;
    logic  wr_ok;
    ptr_t  widx;

    always_comb begin
        slot_ent[0] = '{inst: inst_0, pc: pc_0, pred_taken: pred_taken_0};
        slot_ent[1] = '{inst: inst_1, pc: pc_1, pred_taken: pred_taken_1};
        slot_ent[2] = '{inst: inst_2, pc: pc_2, pred_taken: pred_taken_2};
        slot_ent[3] = '{inst: inst_3, pc: pc_3, pred_taken: pred_taken_3};
        slot_ent[4] = '{inst: inst_4, pc: pc_4, pred_taken: pred_taken_4};
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        mem_d   = mem_q;
        widx    = '0;

        rd     = (cnt_t'(dec_accept) < count_q) ? cnt_t'(dec_accept) : count_q;
        room   = ROOM_MAX - room_t'(count_q) + room_t'(rd);
        wr_req = fetch_valid && (fetch_count != 3'd0) && (fetch_count <= 3'd5);
        // Room counts entries freed by this cycle's read, so full+read+write works.
        wr_ok  = wr_req && (room >= room_t'(fetch_count));

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_req && !wr_ok) begin
                ovf_d = 1'b1;
            end
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                if (wr_ok && (i < 32'(fetch_count))) begin
                    widx        = tail_q + ptr_t'(i);
                    mem_d[widx] = slot_ent[i];
                end
            end
            tail_d  = tail_q + (wr_ok ? ptr_t'(fetch_count) : '0);
            head_d  = head_q + ptr_t'(rd);
            count_d = count_q + (wr_ok ? cnt_t'(fetch_count) : '0) - rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
            dec_ent[k] = mem_q[head_q + ptr_t'(k)];
            dec_vld[k] = (cnt_t'(k) < count_q) && !flush;
        end
    end

    assign dec_valid_0      = dec_vld[0];
    assign dec_valid_1      = dec_vld[1];
    assign dec_valid_2      = dec_vld[2];
    assign dec_inst_0       = dec_ent[0].inst;
    assign dec_inst_1       = dec_ent[1].inst;
    assign dec_inst_2       = dec_ent[2].inst;
    assign dec_pc_0         = dec_ent[0].pc;
    assign dec_pc_1         = dec_ent[1].pc;
    assign dec_pc_2         = dec_ent[2].pc;
    assign dec_pred_taken_0 = dec_ent[0].pred_taken;
    assign dec_pred_taken_1 = dec_ent[1].pred_taken;
    assign dec_pred_taken_2 = dec_ent[2].pred_taken;

    assign buble        = (count_q > BUBLE_TH) || flush;
    assign occupancy    = count_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: accepted fetch slots are queued in
// program order and compared against the decode window as they are consumed.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pt;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [2:0]  fetch_count = 3'd0;
    logic [31:0] g_inst [5];
    logic [31:0] g_pc   [5];
    logic        g_pt   [5];
    logic        flush = 1'b0;
    logic [1:0]  dec_accept = 2'd0;
    logic        dec_valid [3];
    logic [31:0] dec_inst  [3];
    logic [31:0] dec_pc    [3];
    logic        dec_pt    [3];
    logic        buble;
    logic [4:0]  occupancy;
    logic        overflow_err;

    ent_t        sb[$];
    logic        m_ovf = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic [15:0] seq = 16'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_count(fetch_count),
        .inst_0(g_inst[0]), .inst_1(g_inst[1]), .inst_2(g_inst[2]),
        .inst_3(g_inst[3]), .inst_4(g_inst[4]),
        .pc_0(g_pc[0]), .pc_1(g_pc[1]), .pc_2(g_pc[2]), .pc_3(g_pc[3]), .pc_4(g_pc[4]),
        .pred_taken_0(g_pt[0]), .pred_taken_1(g_pt[1]), .pred_taken_2(g_pt[2]),
        .pred_taken_3(g_pt[3]), .pred_taken_4(g_pt[4]),
        .flush(flush), .dec_accept(dec_accept),
        .dec_valid_0(dec_valid[0]), .dec_valid_1(dec_valid[1]), .dec_valid_2(dec_valid[2]),
        .dec_inst_0(dec_inst[0]), .dec_inst_1(dec_inst[1]), .dec_inst_2(dec_inst[2]),
        .dec_pc_0(dec_pc[0]), .dec_pc_1(dec_pc[1]), .dec_pc_2(dec_pc[2]),
        .dec_pred_taken_0(dec_pt[0]), .dec_pred_taken_1(dec_pt[1]),
        .dec_pred_taken_2(dec_pt[2]),
        .buble(buble), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fills all five slots; only the first fc are meant to be written.
    task automatic set_group(input int fc);
        for (int i = 0; i < 5; i++) begin
            g_pc[i]   = next_pc + 32'(4 * i);
            g_inst[i] = {8'hA5, 8'(i), seq};
            g_pt[i]   = (i == fc - 1) && next_pc[3];
        end
        seq++;
        if (fc >= 1 && fc <= 5) next_pc = next_pc + 32'(4 * fc);
    endtask

    task automatic check_outputs(input logic fl);
        check_eq("occupancy", 64'(occupancy), 64'(sb.size()));
        check_eq("buble", 64'(buble), 64'((sb.size() > DEPTH - 5) || fl));
        check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("dec_valid_%0d", k), 64'(dec_valid[k]),
                     64'((k < sb.size()) && !fl));
            if (k < sb.size() && !fl) begin
                check_eq($sformatf("dec_pc_%0d", k), 64'(dec_pc[k]), 64'(sb[k].pc));
                check_eq($sformatf("dec_inst_%0d", k), 64'(dec_inst[k]), 64'(sb[k].inst));
                check_eq($sformatf("dec_pred_taken_%0d", k), 64'(dec_pt[k]), 64'(sb[k].pt));
            end
        end
    endtask

    // One cycle: drive, check the current window, then advance the model at the edge.
    task automatic step(input logic fv, input int fc, input int acc, input logic fl);
        int rd;
        int room;
        bit wr;
        fetch_valid = fv;
        fetch_count = 3'(fc);
        dec_accept  = 2'(acc);
        flush       = fl;
        #2;
        check_outputs(fl);
        rd   = (acc < sb.size()) ? acc : sb.size();
        room = DEPTH - sb.size() + rd;
        wr   = fv && fc >= 1 && fc <= 5;
        if (fl) begin
            sb.delete();
        end else begin
            for (int i = 0; i < rd; i++) void'(sb.pop_front());
            if (wr && room < fc) m_ovf = 1'b1;
            else if (wr) begin
                for (int i = 0; i < fc; i++) sb.push_back('{g_inst[i], g_pc[i], g_pt[i]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            g_inst[i] = '0; g_pc[i] = '0; g_pt[i] = 1'b0;
        end
        #7;
        check_outputs(1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        // basic flow: pcs 0x00..0x10, then consume 3
        set_group(5);
        step(1'b1, 5, 0, 1'b0);
        check_eq("basic_occ5", 64'(occupancy), 64'd5);
        check_eq("basic_pc2", 64'(dec_pc[2]), 64'h08);
        step(1'b0, 0, 3, 1'b0);
        check_eq("basic_pc0_after_read", 64'(dec_pc[0]), 64'h0C);
        check_eq("basic_valid2_after_read", 64'(dec_valid[2]), 64'd0);

        // back-pressure: fill to 12, then read 3
        set_group(5); step(1'b1, 5, 0, 1'b0);
        set_group(5); step(1'b1, 5, 0, 1'b0);
        check_eq("bp_buble_at_12", 64'(buble), 64'd1);
        step(1'b0, 0, 3, 1'b0);
        check_eq("bp_occ_9", 64'(occupancy), 64'd9);
        check_eq("bp_buble_at_9", 64'(buble), 64'd0);

        // flush at occupancy 8 with a fetch present
        step(1'b0, 0, 1, 1'b0);
        set_group(5);
        step(1'b1, 5, 0, 1'b1);
        check_eq("flush_occ0", 64'(occupancy), 64'd0);

        // wrap: reach tail=14,count=11 then write 5 + read 3
        set_group(5); step(1'b1, 5, 0, 1'b0);
        set_group(5); step(1'b1, 5, 0, 1'b0);
        set_group(4); step(1'b1, 4, 0, 1'b0);
        step(1'b0, 0, 3, 1'b0);
        set_group(5); step(1'b1, 5, 3, 1'b0);
        check_eq("wrap_occ13", 64'(occupancy), 64'd13);
        check_eq("wrap_tail3", 64'(dut.tail_q), 64'd3);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 3, 1'b0);

        // overflow: occupancy 14, write 5 with no read
        set_group(5); step(1'b1, 5, 0, 1'b0);
        set_group(5); step(1'b1, 5, 0, 1'b0);
        set_group(4); step(1'b1, 4, 0, 1'b0);
        set_group(5); step(1'b1, 5, 0, 1'b0);
        check_eq("ovf_occ14", 64'(occupancy), 64'd14);
        check_eq("ovf_sticky", 64'(overflow_err), 64'd1);
        step(1'b0, 0, 0, 1'b1);
        check_eq("ovf_after_flush", 64'(overflow_err), 64'd1);

        // mixed random traffic
        for (int c = 0; c < 80; c++) begin
            int fc;
            fc = int'($urandom_range(0, 7));
            set_group(fc);
            step(($urandom_range(0, 3) != 0), fc, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0));
        end

        // asynchronous reset mid-traffic
        set_group(5); step(1'b1, 5, 0, 1'b0);
        reset = 1'b0;
        #2;
        sb.delete();
        m_ovf = 1'b0;
        check_outputs(1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Circular instruction queue between `pc_ctrl_super`/instruction memory and the superscalar decode stage. Accepts a fetch group of up to 5 instructions per cycle, each with its PC and predicted-taken flag, and presents the oldest 3 entries to decode in program order. It generates `buble` back-pressure to PC control when it lacks room for a full group. On a misprediction it flushes all contents.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction and PC width.
- `DEPTH`, 16: queue entries; power of two, at least 8.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-low.
- `fetch_valid`  in  1  — a fetch group is present this cycle.
- `fetch_count`  in  3  — valid slots in the group, 1..5, filled from slot 0 upward; 0 or values above 5 mean no write.
- `inst_0`..`inst_4`  in  DATA_WIDTH  — fetched instructions.
- `pc_0`..`pc_4`  in  DATA_WIDTH  — PCs of the slots, from `current_pc_*`.
- `pred_taken_0`..`pred_taken_4`  in  1  — the slot redirected fetch (jump/jalr); later slots are already excluded by `fetch_count`.
- `flush`  in  1  — misprediction; discard everything.
- `dec_accept`  in  2  — entries decode consumes this cycle, 0..3; clipped to the number valid.
- `dec_valid_0`..`dec_valid_2`  out  1  — entry at head+k is valid.
- `dec_inst_0`..`dec_inst_2`, `dec_pc_0`..`dec_pc_2`  out  DATA_WIDTH  — entry contents.
- `dec_pred_taken_0`..`dec_pred_taken_2`  out  1  — predicted-taken flag of the entry.
- `buble`  out  1  — stall to PC control.
- `occupancy`  out  $clog2(DEPTH)+1  — current entry count.
- `overflow_err`  out  1  — sticky; an accepted write would have exceeded capacity.

## Operation
- State:
  - `head` and `tail`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, $clog2(DEPTH)+1 bits.
  - Entry array of {inst, pc, pred_taken}.
- Write: when `fetch_valid` is high and `fetch_count` is in 1..5, write slot i to `tail+i` mod DEPTH for i < `fetch_count`, and advance `tail` by `fetch_count`.
- Capacity check:
  - A write is dropped entirely if `DEPTH - count + rd < fetch_count`, where rd is the clipped read count this cycle.
  - A dropped write sets `overflow_err`, which stays set until reset.
- Read:
  - rd = min(`dec_accept`, count, 3).
  - `head` advances by rd.
  - `dec_*_k` show the entry at `head+k` mod DEPTH.
  - `dec_valid_k` = (k < count) and not `flush`.
- Count update: next count = count + wr − rd. Read and write in the same cycle are legal, including at full or empty.
- `buble` = (count > DEPTH − 5) or `flush`. It is combinational from registered state plus `flush`.
- Flush:
  - At the edge: `head`, `tail` and `count` are cleared to 0.
  - Same-cycle writes and reads are discarded.
  - `overflow_err` is unaffected.
- Reset:
  - `head`, `tail`, `count` and `overflow_err` go to 0, so every `dec_valid_k` is 0 and `buble` is 0.
  - Entry contents are don't-care.
  - Assertion mid-operation takes effect immediately (asynchronous).

## Timing
- Write-to-read latency is 1 cycle: a group written at edge N is visible on `dec_*` after edge N, if it is at the head.
- No bypass from the fetch inputs to the decode outputs.
- Read outputs are combinational from `head`/`count` and the array. No output register.
- `buble` responds in the same cycle as `count` changes; `pc_ctrl_super` samples it at the next edge.
- Flush: `flush` high in cycle N masks `dec_valid` in cycle N. The queue is empty from N+1, and it can accept a fetch at the redirected PC in N+1.
- Wrap-around: a 5-entry write starting at `tail` = DEPTH−2 occupies indices DEPTH−2, DEPTH−1, 0, 1, 2.

## Structure
- Shared package `fetch_pkg`:
  - constants `FETCH_WIDTH = 5` and `DECODE_WIDTH = 3`;
  - typedef `fetch_entry_t` = packed struct {inst, pc, pred_taken}.
- Single module. Storage, pointers and muxes are inline; no sub-module is warranted.
- Slot ports are flattened to match the neighbouring stages' per-slot port style.

## Test plan
- **Reset:** assert `reset`=0 mid-traffic → all `dec_valid_k`=0, `occupancy`=0, `buble`=0, `overflow_err`=0.
- **Basic flow:**
  - Stimulus: write 5 instructions with `pc_0`..`pc_4` = 0x00,0x04,…,0x10, and `dec_accept`=0.
  - Response: `occupancy`=5.
  - Then: `dec_pc_0`..`dec_pc_2` = 0x00,0x04,0x08.
  - Then `dec_accept`=3: next cycle `dec_pc_0`=0x0C, `dec_valid_2`=0, `occupancy`=2.
- **Back-pressure (DEPTH=16):** fill to 12 → `buble`=1. Read 3 with no write → `occupancy`=9, `buble`=0.
- **Simultaneous read/write at wrap:**
  - Stimulus: `tail`=14, `count`=11, write 5 and accept 3 in the same cycle.
  - Response: `occupancy`=13, `tail`=3, program order preserved across the index 15→0 boundary.
- **Flush:**
  - Stimulus: `occupancy`=8, `flush`=1 with `fetch_valid`=1.
  - Response: same cycle `dec_valid_k`=0 and `buble`=1; next cycle `occupancy`=0 and the group is not written.
- **Overflow:**
  - Stimulus: `occupancy`=14, write `fetch_count`=5 with `dec_accept`=0.
  - Response: write dropped, `occupancy`=14, `overflow_err`=1 sticky through a later flush.
